// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank: oversampled I2C target with an auto-incrementing pointer into a byte register bank.
module i2c_target_regbank #(
   parameter logic [6:0] ADDRESS     = 7'd89,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        PTR_W       = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_scl,
   input  logic             i_sda,
   output logic             o_sda_oe,
   output logic [PTR_W-1:0] o_reg_addr,
   output logic             o_wr_en,
   output logic [7:0]       o_wr_data,
   input  logic [7:0]       i_rd_data,
   output logic             o_busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_d, sda_d, scl_s, sda_s;
   logic scl_rise, scl_fall, start, stop;
   logic [3:0] cnt, cnt_n;
   logic [7:0] shift, shift_n, wr_data_n;
   logic rw, rw_n, oe_n, wr_en_n, busy_n, ptr_ok;
   logic [PTR_W-1:0] ptr_n, ptr_inc;
   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start    = scl_s & sda_d & ~sda_s;
   assign stop     = scl_s & ~sda_d & sda_s;
   assign ptr_inc  = (o_reg_addr == PTR_W'(NUM_REGS - 1)) ? '0 : o_reg_addr + 1'b1;
   assign ptr_ok   = {1'b0, shift} < 9'(NUM_REGS);
   // Synchronisers rest at 1 so leaving reset on an idle bus creates no edges.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         rw         <= 1'b0;
         o_sda_oe   <= 1'b0;
         o_reg_addr <= '0;
         o_wr_en    <= 1'b0;
         o_wr_data  <= '0;
         o_busy     <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shift      <= shift_n;
         rw         <= rw_n;
         o_sda_oe   <= oe_n;
         o_reg_addr <= ptr_n;
         o_wr_en    <= wr_en_n;
         o_wr_data  <= wr_data_n;
         o_busy     <= busy_n;
      end
   end
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      shift_n   = shift;
      rw_n      = rw;
      oe_n      = o_sda_oe;
      ptr_n     = o_wr_en ? ptr_inc : o_reg_addr;
      wr_en_n   = 1'b0;
      wr_data_n = o_wr_data;
      busy_n    = o_busy;
      if (start || stop) begin
         state_n = start ? ADDR : IDLE;
         cnt_n   = '0;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (scl_rise) begin
         if ((state == ADDR || state == PTR || state == WDATA) && cnt != 4'd8) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
         end
         // The controller's acknowledge of a read byte is parked in shift[0].
         if (state == RDATA_ACK) shift_n[0] = sda_s;
      end else if (scl_fall) begin
         case (state)
            ADDR: if (cnt == 4'd8) begin
               cnt_n   = '0;
               state_n = (shift[7:1] == ADDRESS) ? ADDR_ACK : IGNORE;
               oe_n    = shift[7:1] == ADDRESS;
               busy_n  = shift[7:1] == ADDRESS;
               rw_n    = shift[0];
            end
            PTR: if (cnt == 4'd8) begin
               cnt_n   = '0;
               state_n = ptr_ok ? PTR_ACK : IGNORE;
               oe_n    = ptr_ok;
               ptr_n   = ptr_ok ? shift[PTR_W-1:0] : o_reg_addr;
            end
            WDATA: if (cnt == 4'd8) begin
               cnt_n     = '0;
               state_n   = WDATA_ACK;
               oe_n      = 1'b1;
               wr_en_n   = 1'b1;
               wr_data_n = shift;
            end
            RDATA: if (cnt == 4'd8) begin
               cnt_n   = '0;
               state_n = RDATA_ACK;
               oe_n    = 1'b0;
               ptr_n   = ptr_inc;
            end else begin
               oe_n    = ~shift[6];
               shift_n = {shift[6:0], 1'b0};
               cnt_n   = cnt + 4'd1;
            end
            PTR_ACK, WDATA_ACK: begin
               state_n = WDATA;
               oe_n    = 1'b0;
            end
            ADDR_ACK, RDATA_ACK: if ((state == ADDR_ACK && !rw) || (state == RDATA_ACK && shift[0])) begin
               state_n = (state == ADDR_ACK) ? PTR : IGNORE;
               oe_n    = 1'b0;
            end else begin
               state_n = RDATA;
               shift_n = i_rd_data;
               oe_n    = ~i_rd_data[7];
               cnt_n   = 4'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_target_regbank.sv
// tb_i2c_target_regbank: directed I2C controller transactions against the target with hand-computed expectations.
module tb_i2c_target_regbank;
   logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, ctl_sda = 1'b1;
   logic bus_sda, sda_oe, wr_en, busy;
   logic [3:0] reg_addr;
   logic [7:0] wr_data, rd_data;
   logic [7:0] regs [16];
   logic [3:0] wa [$];
   logic [7:0] wd [$];
   int checks = 0, failures = 0, oe_cnt = 0, busy_cnt = 0;
   assign bus_sda = ctl_sda & ~sda_oe;
   assign rd_data = regs[reg_addr];
   always #5 clk = ~clk;
   i2c_target_regbank dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .i_sda(bus_sda), .o_sda_oe(sda_oe),
      .o_reg_addr(reg_addr), .o_wr_en(wr_en), .o_wr_data(wr_data), .i_rd_data(rd_data), .o_busy(busy)
   );
   always @(negedge clk) begin
      if (wr_en) begin
         wa.push_back(reg_addr);
         wd.push_back(wr_data);
      end
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
   end
   task automatic quarter;
      repeat (4) @(negedge clk);
   endtask
   task automatic i2c_start;
      ctl_sda = 1'b1; quarter; scl = 1'b1; quarter; ctl_sda = 1'b0; quarter; scl = 1'b0; quarter;
   endtask
   task automatic i2c_stop;
      ctl_sda = 1'b0; quarter; scl = 1'b1; quarter; ctl_sda = 1'b1; quarter; quarter;
   endtask
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         ctl_sda = b[i]; quarter; scl = 1'b1; quarter; quarter; scl = 1'b0; quarter;
      end
      ctl_sda = 1'b1; quarter; scl = 1'b1; quarter; ack = ~bus_sda; quarter; scl = 1'b0; quarter;
   endtask
   task automatic read_byte(input logic nack, output logic [7:0] b);
      ctl_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         quarter; scl = 1'b1; quarter; b[i] = bus_sda; quarter; scl = 1'b0; quarter;
      end
      ctl_sda = nack; quarter; scl = 1'b1; quarter; quarter; scl = 1'b0; quarter;
   endtask
   task automatic test_reset;
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (reg_addr !== 4'd0) begin failures++; $display("FAIL reset_reg_addr got=%0d exp=0", reg_addr); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask
   task automatic test_write;
      int base = wa.size();
      logic a0, a1, a2, a3;
      i2c_start; send_byte(8'hB2, a0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", busy); end
      send_byte(8'h03, a1); send_byte(8'hA5, a2); send_byte(8'h5A, a3); i2c_stop;
      checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL write_acks got=%b exp=1111", {a0, a1, a2, a3}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
      checks++; if (wa.size() - base !== 2) begin failures++; $display("FAIL write_count got=%0d exp=2", wa.size() - base); end
      else begin
         checks++; if ({wa[base], wd[base]} !== {4'd3, 8'hA5}) begin failures++; $display("FAIL write_first got=%0d/%h exp=3/a5", wa[base], wd[base]); end
         checks++; if ({wa[base+1], wd[base+1]} !== {4'd4, 8'h5A}) begin failures++; $display("FAIL write_second got=%0d/%h exp=4/5a", wa[base+1], wd[base+1]); end
      end
      checks++; if (reg_addr !== 4'd5) begin failures++; $display("FAIL write_ptr got=%0d exp=5", reg_addr); end
   endtask
   task automatic test_wrap;
      int base = wa.size();
      logic a;
      i2c_start; send_byte(8'hB2, a); send_byte(8'h0F, a); send_byte(8'h11, a); send_byte(8'h22, a); i2c_stop;
      checks++; if (wa.size() - base !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wa.size() - base); end
      else begin
         checks++; if ({wa[base], wd[base]} !== {4'd15, 8'h11}) begin failures++; $display("FAIL wrap_first got=%0d/%h exp=15/11", wa[base], wd[base]); end
         checks++; if ({wa[base+1], wd[base+1]} !== {4'd0, 8'h22}) begin failures++; $display("FAIL wrap_second got=%0d/%h exp=0/22", wa[base+1], wd[base+1]); end
      end
      checks++; if (reg_addr !== 4'd1) begin failures++; $display("FAIL wrap_ptr got=%0d exp=1", reg_addr); end
   endtask
   task automatic test_read;
      int base = wa.size();
      logic a0, a1, a2;
      logic [7:0] b0, b1;
      i2c_start; send_byte(8'hB2, a0); send_byte(8'h07, a1);
      i2c_start; send_byte(8'hB3, a2);
      read_byte(1'b0, b0); read_byte(1'b1, b1);
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_release got=%b exp=0", sda_oe); end
      i2c_stop;
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL read_acks got=%b exp=111", {a0, a1, a2}); end
      checks++; if (b0 !== 8'h3C) begin failures++; $display("FAIL read_byte0 got=%h exp=3c", b0); end
      checks++; if (b1 !== 8'hC3) begin failures++; $display("FAIL read_byte1 got=%h exp=c3", b1); end
      checks++; if (wa.size() !== base) begin failures++; $display("FAIL read_no_write got=%0d exp=0", wa.size() - base); end
      checks++; if (reg_addr !== 4'd9) begin failures++; $display("FAIL read_ptr got=%0d exp=9", reg_addr); end
   endtask
   task automatic test_mismatch;
      int base = wa.size(), oe0 = oe_cnt, busy0 = busy_cnt;
      logic a0, a1, a2, a3;
      i2c_start; send_byte(8'hB4, a0); send_byte(8'h01, a1); send_byte(8'h00, a2); send_byte(8'hFF, a3); i2c_stop;
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL mismatch_acks got=%b exp=0000", {a0, a1, a2, a3}); end
      checks++; if (oe_cnt !== oe0) begin failures++; $display("FAIL mismatch_sda_oe got=%0d exp=0 cycles", oe_cnt - oe0); end
      checks++; if (busy_cnt !== busy0) begin failures++; $display("FAIL mismatch_busy got=%0d exp=0 cycles", busy_cnt - busy0); end
      checks++; if (wa.size() !== base) begin failures++; $display("FAIL mismatch_no_write got=%0d exp=0", wa.size() - base); end
   endtask
   task automatic test_bad_ptr;
      int base = wa.size();
      logic a0, a1, a2;
      i2c_start; send_byte(8'hB2, a0); send_byte(8'h10, a1); send_byte(8'h77, a2); i2c_stop;
      checks++; if ({a0, a1, a2} !== 3'b100) begin failures++; $display("FAIL badptr_acks got=%b exp=100", {a0, a1, a2}); end
      checks++; if (wa.size() !== base) begin failures++; $display("FAIL badptr_no_write got=%0d exp=0", wa.size() - base); end
      checks++; if (reg_addr !== 4'd9) begin failures++; $display("FAIL badptr_ptr got=%0d exp=9", reg_addr); end
   endtask
   task automatic test_reset_mid_read;
      logic a;
      i2c_start; send_byte(8'hB2, a); send_byte(8'h02, a);
      i2c_start; send_byte(8'hB3, a);
      checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL midread_drive got=%b exp=1", sda_oe); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL midread_release got=%b exp=0", sda_oe); end
      scl = 1'b1; ctl_sda = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if ({busy, reg_addr} !== 5'd0) begin failures++; $display("FAIL midread_state got=%b/%0d exp=0/0", busy, reg_addr); end
      rst_n = 1'b1; quarter;
   endtask
   task automatic test_back_to_back;
      int base = wa.size();
      logic a0, a1, a2, a3, a4, a5, a6;
      i2c_start; send_byte(8'hB2, a0); send_byte(8'h06, a1); send_byte(8'h99, a2); i2c_stop;
      i2c_start; send_byte(8'hB2, a3); send_byte(8'h0E, a4); send_byte(8'h42, a5); send_byte(8'h24, a6); i2c_stop;
      checks++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin failures++; $display("FAIL b2b_acks got=%b exp=1111111", {a0, a1, a2, a3, a4, a5, a6}); end
      checks++; if (wa.size() - base !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", wa.size() - base); end
      else begin
         checks++; if ({wa[base], wd[base]} !== {4'd6, 8'h99}) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=6/99", wa[base], wd[base]); end
         checks++; if ({wa[base+1], wd[base+1]} !== {4'd14, 8'h42}) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=14/42", wa[base+1], wd[base+1]); end
         checks++; if ({wa[base+2], wd[base+2]} !== {4'd15, 8'h24}) begin failures++; $display("FAIL b2b_third got=%0d/%h exp=15/24", wa[base+2], wd[base+2]); end
      end
      checks++; if (reg_addr !== 4'd0) begin failures++; $display("FAIL b2b_ptr got=%0d exp=0", reg_addr); end
   endtask
   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      regs[2] = 8'h5A;
      regs[7] = 8'h3C;
      regs[8] = 8'hC3;
      repeat (5) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      quarter;
      test_write;
      test_wrap;
      test_read;
      test_mismatch;
      test_bad_ptr;
      test_reset_mid_read;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
